des_iter_ctrl: RTL and testbench
================================

// Module: des_iter_ctrl
// PURPOSE
//  Iterative DES engine controller: sequences one bank of Fiestel rounds over
//  16/ROUNDS_PER_CYCLE clocks instead of the 16-stage unrolled DES datapath.
//  Owns the round counter, the L/R half-block registers, the subkey select from
//  key_scheduler and the valid/ready handshakes. Sits between the host bus and
//  the shared initial_permutation/Fiestel/final_permutation primitives.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  Fiestel instances chained per clock. Legal values: 1, 2, 4, 8, 16.
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   asynchronous, active-high reset
//  in_valid    in   1   plaintext/key offered
//  in_ready    out  1   block can accept a job
//  plaintext   in   64  input block, sampled on accept
//  key         in   64  DES key with parity bits, sampled on accept
//  out_valid   out  1   ciphertext valid
//  out_ready   in   1   consumer takes ciphertext
//  ciphertext  out  64  result, registered
//  busy        out  1   high in RUN or DONE
// BEHAVIOUR
//  Reset (async assert): state=IDLE, rnd=0, L/R/key_q/ciphertext=0,
//   out_valid=0, busy=0. in_ready=1 once reset is released.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: in_ready=1. On in_valid&&in_ready, load {L,R}=IP(plaintext),
//    key_q=key, rnd=0, go to RUN.
//   RUN: each clock applies R=ROUNDS_PER_CYCLE rounds:
//    L'=R, R'=L^F(R,subkey[rnd+i]) for i=0..R-1. rnd+=R.
//    When rnd+R==16: ciphertext<=FP({R16,L16}) (swap, no final round swap),
//    out_valid<=1, go to DONE.
//   DONE: out_valid=1, ciphertext stable until out_valid&&out_ready.
//    On handshake: if in_valid also high, accept the new job in the same clock
//    (load as in IDLE, go to RUN). Otherwise go to IDLE.
//  in_ready = (state==IDLE) || (state==DONE && out_ready). No combinational path
//   from in_valid to in_ready.
//  Latency: job accepted at edge k -> out_valid high after edge k+16/R.
//   Throughput is one job per 16/R+1 clocks with out_ready held high.
//  Subkeys: key_scheduler is driven from key_q only. Changes on plaintext/key
//   after accept are ignored. rnd is 4 bits and is never allowed to wrap past 15.
//  ciphertext holds its last value after the handshake until the next job completes.
//  Reset during RUN or DONE abandons the job: no out_valid pulse, state=IDLE.
//  out_valid and ciphertext do not change while out_ready=0. Backpressure is
//   unlimited.
// CONFIGURATION
//  DES_ITER_DECRYPT_EN defined:
//   - adds input port decrypt (1 bit), sampled on accept into decrypt_q.
//   - decrypt_q=1 selects subkey[15-rnd-i] (reverse order); the datapath is unchanged.
//  DES_ITER_DECRYPT_EN undefined:
//   - the decrypt port is absent.
//   - the block encrypts only, using subkey[rnd+i].
// TESTING
//  1) key=133457799BBCDFF1, pt=0123456789ABCDEF, out_ready=1 -> ct=85E813540F0AB405,
//     out_valid 16 clocks after accept (R=1).
//  2) key=0000000000000000, pt=0000000000000000 -> ct=8CA64DE9C1B123A7.
//     Repeat for R=1,2,4,16 with latencies 16,8,4,1.
//  3) Backpressure: out_ready=0 for 20 clocks after out_valid -> ct is stable,
//     in_ready=0 until out_ready=1. Then the handshake occurs and state=IDLE.
//  4) Back-to-back: in_valid held with two jobs, out_ready=1 -> the second job is
//     accepted in the DONE handshake clock and both results match the vectors.
//  5) rst pulsed at rnd=7 -> no out_valid, in_ready=1 after release.
//     The next job (vector 1) produces the correct result.
//  6) DES_ITER_DECRYPT_EN: decrypt=1, key=133457799BBCDFF1, input=85E813540F0AB405
//     -> 0123456789ABCDEF.

Source files
------------

// File: rtl/des_iter_ctrl.sv
// Iterative DES engine: ROUNDS_PER_CYCLE Feistel rounds per clock over a shared round datapath.
// Optional feature macro DES_ITER_DECRYPT_EN adds a decrypt input that walks the subkeys in reverse.
module des_iter_ctrl #(
   parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] plaintext,
   input  logic [63:0] key,
`ifdef DES_ITER_DECRYPT_EN
   input  logic        decrypt,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] ciphertext,
   output logic        busy
);

   // DES tables, 1-based bit numbers counted from the MSB
   localparam int unsigned IP_T [64] = '{
      58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
   localparam int unsigned FP_T [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
   localparam int unsigned E_T [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
      12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
      22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
   localparam int unsigned P_T [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
   localparam int unsigned PC1_T [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int unsigned PC2_T [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   // Cumulative left-rotation of C/D after each round
   localparam int unsigned SHIFT_CUM [16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};
   localparam int unsigned SBOX [8][64] = '{
      '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,   0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
         4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,  15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
      '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,   3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
         0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,  13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
      '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,   13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
        13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,   1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
      '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,   13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
        10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,   3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
      '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,   14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
         4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,  11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
      '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,   10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
         9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,  4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
      '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,   13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
         1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,  6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
      '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,   1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
         7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,  2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_T[6'(i)])];
      return y;
   endfunction

   // Key schedule evaluated directly for round n from the stored key
   function automatic logic [47:0] subkey(input logic [63:0] k, input logic [3:0] n);
      logic [55:0] cd;
      logic [55:0] c2;
      logic [55:0] d2;
      logic [55:0] cd_r;
      logic [47:0] y;
      cd = '0;
      y  = '0;
      for (int i = 0; i < 56; i++) cd[6'(55 - i)] = k[6'(64 - PC1_T[6'(i)])];
      c2   = {cd[55:28], cd[55:28]} << SHIFT_CUM[n];
      d2   = {cd[27:0], cd[27:0]} << SHIFT_CUM[n];
      cd_r = {c2[55:28], d2[55:28]};
      for (int i = 0; i < 48; i++) y[6'(47 - i)] = cd_r[6'(56 - PC2_T[6'(i)])];
      return y;
   endfunction

   function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
      logic [47:0] x;
      logic [5:0]  six;
      logic [31:0] s;
      logic [31:0] y;
      x = '0;
      s = '0;
      y = '0;
      for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_T[6'(i)])];
      x = x ^ k;
      for (int b = 0; b < 8; b++) begin
         six = x[6'(47 - 6 * b) -: 6];
         s[5'(31 - 4 * b) -: 4] = 4'(SBOX[3'(b)][{six[5], six[0], six[4:1]}]);
      end
      for (int i = 0; i < 32; i++) y[5'(31 - i)] = s[5'(32 - P_T[5'(i)])];
      return y;
   endfunction

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] l_q, r_q, l_nxt, r_nxt, l_t, r_t, f_t;
   logic [63:0] key_q, key_nxt, ct_nxt, ip_t;
   logic [3:0]  rnd, rnd_nxt, idx;
   logic        ov_nxt, accept, last_step;
`ifdef DES_ITER_DECRYPT_EN
   logic        decrypt_q, dec_nxt;
`endif

   assign in_ready = (state == IDLE) || (state == DONE && out_ready);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   // Next state plus one bank of rounds from the registered halves
   always_comb begin
      state_nxt = state;
      l_nxt     = l_q;
      r_nxt     = r_q;
      key_nxt   = key_q;
      rnd_nxt   = rnd;
      ct_nxt    = ciphertext;
      ov_nxt    = out_valid;
`ifdef DES_ITER_DECRYPT_EN
      dec_nxt   = decrypt_q;
`endif
      l_t       = l_q;
      r_t       = r_q;
      f_t       = '0;
      idx       = '0;
      ip_t      = perm_ip(plaintext);
      last_step = (5'({1'b0, rnd}) + 5'(ROUNDS_PER_CYCLE)) == 5'd16;
      for (int i = 0; i < int'(ROUNDS_PER_CYCLE); i++) begin
         idx = rnd + 4'(i);
`ifdef DES_ITER_DECRYPT_EN
         if (decrypt_q) idx = 4'd15 - rnd - 4'(i);
`endif
         f_t = feistel(r_t, subkey(key_q, idx));
         {l_t, r_t} = {r_t, l_t ^ f_t};
      end
      case (state)
         IDLE: ;
         RUN: begin
            l_nxt = l_t;
            r_nxt = r_t;
            if (last_step) begin
               ct_nxt    = perm_fp({r_t, l_t});
               ov_nxt    = 1'b1;
               state_nxt = DONE;
            end else begin
               rnd_nxt = rnd + 4'(ROUNDS_PER_CYCLE);
            end
         end
         DONE: begin
            if (out_ready) begin
               ov_nxt    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // A DONE handshake can take the next job in the same clock
      if (accept) begin
         {l_nxt, r_nxt} = ip_t;
         key_nxt        = key;
         rnd_nxt        = '0;
         state_nxt      = RUN;
`ifdef DES_ITER_DECRYPT_EN
         dec_nxt        = decrypt;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         l_q        <= '0;
         r_q        <= '0;
         key_q      <= '0;
         rnd        <= '0;
         ciphertext <= '0;
         out_valid  <= 1'b0;
`ifdef DES_ITER_DECRYPT_EN
         decrypt_q  <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         l_q        <= l_nxt;
         r_q        <= r_nxt;
         key_q      <= key_nxt;
         rnd        <= rnd_nxt;
         ciphertext <= ct_nxt;
         out_valid  <= ov_nxt;
`ifdef DES_ITER_DECRYPT_EN
         decrypt_q  <= dec_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_des_iter_ctrl.sv
// Randomized bench for des_iter_ctrl: four instances (1/2/4/16 rounds per clock) run the same job list
// against a job-level model built from known-answer vectors, DES complementation and parity-bit don't-cares.
module tb_des_iter_ctrl;

   localparam int NINST   = 4;
   localparam int NJOBS   = 24;
   localparam int RST_JOB = 9;
   localparam int BUDGET  = 20000;
   localparam int unsigned RPCS [NINST] = '{1, 2, 4, 16};
   localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] PARITY = 64'h0101_0101_0101_0101;
   localparam logic [63:0] KAT_KEY [3] = '{64'h133457799BBCDFF1, 64'h0000000000000000, 64'h0E329232EA6D0D73};
   localparam logic [63:0] KAT_PT  [3] = '{64'h0123456789ABCDEF, 64'h0000000000000000, 64'h8787878787878787};
   localparam logic [63:0] KAT_CT  [3] = '{64'h85E813540F0AB405, 64'h8CA64DE9C1B123A7, 64'h0000000000000000};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [NINST-1:0]       rst, in_valid, in_ready, out_valid, out_ready, busy, decrypt;
   logic [NINST-1:0][63:0] plaintext, key, ciphertext;

   for (genvar g = 0; g < NINST; g++) begin : g_dut
      des_iter_ctrl #(.ROUNDS_PER_CYCLE(RPCS[g])) u_dut (
         .clk        (clk),
         .rst        (rst[g]),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .plaintext  (plaintext[g]),
         .key        (key[g]),
`ifdef DES_ITER_DECRYPT_EN
         .decrypt    (decrypt[g]),
`endif
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .ciphertext (ciphertext[g]),
         .busy       (busy[g])
      );
   end

   int unsigned errors = 0;
   int unsigned checks = 0;
   int          cyc    = 0;

   logic [63:0] job_key [NJOBS];
   logic [63:0] job_pt  [NJOBS];
   logic [63:0] job_ct  [NJOBS];
   logic        job_dec [NJOBS];

   // Per-instance job-level model state
   logic        pending  [NINST];
   int          acc_cyc  [NINST];
   logic [63:0] exp_ct   [NINST];
   logic [63:0] last_ct  [NINST];
   int          next_job [NINST];
   logic        acc_f    [NINST];
   logic        del_f    [NINST];
   int          stall    [NINST];
   int          rst_left [NINST];
   logic        rst_done [NINST];
   logic        fin      [NINST];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step(input int g);
      int   lat;
      logic ov_exp;
      logic ir_exp;
      lat = int'(16 / RPCS[g]);
      if (del_f[g]) pending[g] = 1'b0;
      if (acc_f[g]) begin
         pending[g] = 1'b1;
         acc_cyc[g] = cyc;
         exp_ct[g]  = job_ct[next_job[g]];
         next_job[g]++;
      end
      if (pending[g] && (cyc - acc_cyc[g] == lat)) begin
         last_ct[g] = exp_ct[g];
         if (((next_job[g] - 1) % 7) == 3) stall[g] = 20;
      end
      ov_exp = pending[g] && (cyc - acc_cyc[g] >= lat);
      ir_exp = !pending[g] || (ov_exp && out_ready[g]);
      check($sformatf("r%0d out_valid", RPCS[g]), 64'(out_valid[g]), 64'(ov_exp));
      check($sformatf("r%0d ciphertext", RPCS[g]), ciphertext[g], last_ct[g]);
      check($sformatf("r%0d busy", RPCS[g]), 64'(busy[g]), 64'(pending[g]));
      if (!rst[g]) check($sformatf("r%0d in_ready", RPCS[g]), 64'(in_ready[g]), 64'(ir_exp));
      fin[g] = (next_job[g] == NJOBS) && !pending[g] && (rst_left[g] == 0);

      acc_f[g] = 1'b0;
      del_f[g] = 1'b0;
      if (rst_left[g] > 0) begin
         rst_left[g]--;
         if (rst_left[g] == 0) rst[g] = 1'b0;
         in_valid[g] = 1'b0;
      end else if (!rst_done[g] && next_job[g] == RST_JOB + 1 && pending[g] &&
                   (cyc - acc_cyc[g] == (lat - 1) / 2)) begin
         // Abandon the job mid-run: it must never report completion
         rst[g]       = 1'b1;
         rst_left[g]  = 2;
         rst_done[g]  = 1'b1;
         pending[g]   = 1'b0;
         last_ct[g]   = '0;
         in_valid[g]  = 1'b0;
         out_ready[g] = 1'b0;
      end else begin
         out_ready[g] = (stall[g] > 0) ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (stall[g] > 0) stall[g]--;
         in_valid[g] = (next_job[g] < NJOBS) && ($urandom_range(0, 2) != 0);
         if (in_valid[g]) begin
            plaintext[g] = job_pt[next_job[g]];
            key[g]       = job_key[next_job[g]];
            decrypt[g]   = job_dec[next_job[g]];
         end else begin
            plaintext[g] = {$urandom, $urandom};
            key[g]       = {$urandom, $urandom};
            decrypt[g]   = 1'($urandom_range(0, 1));
         end
         acc_f[g] = in_valid[g] && (!pending[g] || (ov_exp && out_ready[g]));
         del_f[g] = ov_exp && out_ready[g];
      end
   endtask

   initial begin
      int          b;
      logic [63:0] m;
      logic [63:0] tmp;
      logic        all_fin;
      for (int j = 0; j < NJOBS; j++) begin
         b = $urandom_range(0, 2);
         m = ($urandom_range(0, 1) != 0) ? ONES : 64'h0;
         if (j == 0 || j == RST_JOB + 1) begin
            b = 0;
            m = 64'h0;
         end else if (j == 1) begin
            b = 1;
            m = 64'h0;
         end
         job_key[j] = KAT_KEY[b] ^ m;
         if (j > 1) job_key[j] = job_key[j] ^ ({$urandom, $urandom} & PARITY);
         job_pt[j]  = KAT_PT[b] ^ m;
         job_ct[j]  = KAT_CT[b] ^ m;
         job_dec[j] = 1'b0;
`ifdef DES_ITER_DECRYPT_EN
         if (j > 1 && $urandom_range(0, 1) != 0) begin
            job_dec[j] = 1'b1;
            tmp        = job_pt[j];
            job_pt[j]  = job_ct[j];
            job_ct[j]  = tmp;
         end
`endif
      end
      for (int g = 0; g < NINST; g++) begin
         pending[g]  = 1'b0;
         acc_cyc[g]  = 0;
         exp_ct[g]   = '0;
         last_ct[g]  = '0;
         next_job[g] = 0;
         acc_f[g]    = 1'b0;
         del_f[g]    = 1'b0;
         stall[g]    = 0;
         rst_left[g] = 0;
         rst_done[g] = 1'b0;
         fin[g]      = 1'b0;
      end
      rst       = '1;
      in_valid  = '0;
      out_ready = '0;
      decrypt   = '0;
      plaintext = '0;
      key       = '0;
      repeat (2) @(negedge clk);
      for (int g = 0; g < NINST; g++) begin
         check($sformatf("r%0d reset out_valid", RPCS[g]), 64'(out_valid[g]), 64'h0);
         check($sformatf("r%0d reset ciphertext", RPCS[g]), ciphertext[g], 64'h0);
         check($sformatf("r%0d reset busy", RPCS[g]), 64'(busy[g]), 64'h0);
      end
      rst = '0;
      all_fin = 1'b0;
      while (!all_fin && cyc < BUDGET) begin
         @(negedge clk);
         cyc++;
         all_fin = 1'b1;
         for (int g = 0; g < NINST; g++) begin
            step(g);
            if (!fin[g]) all_fin = 1'b0;
         end
      end
      for (int g = 0; g < NINST; g++)
         check($sformatf("r%0d jobs finished", RPCS[g]), 64'(fin[g]), 64'h1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
